syscall_ctrl: RTL and testbench
===============================

SYSCALL_CTRL -- requirements
Module: syscall_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of instruction ID, code, argument and display data.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, display-buffer entries; power of two, >= 2.
REQ-003 SHALL have parameter EXIT_DELAY, default 5, clock cycles between drain complete and halt; >= 1.
REQ-004 SHALL have parameter SYSCALL_ID, default 26, decoded instruction ID identifying a system instruction.
REQ-005 SHALL use one clock and an asynchronous, active-low reset.
REQ-006 clk  input  1  rising-edge clock for all state.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 req_valid  input  1  processor presents a request.
REQ-009 req_ready  output  1  block accepts the request this cycle.
REQ-010 instr_id  input  DATA_W  decoded instruction ID of the request.
REQ-011 sys_code  input  DATA_W  service code (rs): 1 = display, 2 = exit, any other value = nop.
REQ-012 sys_arg  input  DATA_W  argument (rt): value to display.
REQ-013 disp_valid  output  1  display FIFO head is valid.
REQ-014 disp_ready  input  1  consumer takes the head.
REQ-015 disp_data  output  DATA_W  display FIFO head value.
REQ-016 busy  output  1  exit sequence in progress or halted.
REQ-017 halt  output  1  sticky program-termination flag.
REQ-018 sys_count  output  DATA_W  number of accepted syscalls (instr_id == SYSCALL_ID).

Function
REQ-019 States SHALL be RUN, DRAIN, DELAY, HALTED; state, FIFO, counters and all outputs registered except req_ready, disp_valid, disp_data.
REQ-020 req_ready SHALL be 1 iff state == RUN and FIFO not full; request accepted on a rising edge with req_valid && req_ready.
REQ-021 An accepted request with instr_id != SYSCALL_ID SHALL have no effect (no push, no count, no state change).
REQ-022 An accepted syscall SHALL increment sys_count by 1, wrapping from 2^DATA_W-1 to 0.
REQ-023 Display (code 1): sys_arg SHALL be pushed; disp_valid asserts on the cycle after the accepting edge at the earliest.
REQ-024 Nop (code not 1 or 2): no effect except sys_count.
REQ-025 Exit (code 2): state RUN -> DRAIN at the accepting edge; no push.
REQ-026 disp_valid SHALL equal FIFO not empty; disp_data SHALL equal the oldest entry; pop on edge with disp_valid && disp_ready; strict FIFO order.
REQ-027 Full FIFO: req_ready = 0; a pop on that edge raises req_ready on the next cycle; no data ever dropped or overwritten.
REQ-028 Simultaneous push and pop on a non-full, non-empty FIFO SHALL leave occupancy unchanged.
REQ-029 DRAIN: pops continue; at the first edge with the FIFO empty at the start of the cycle, go to DELAY with delay counter = 0.
REQ-030 DELAY: counter increments each edge; at the edge where counter == EXIT_DELAY-1, go to HALTED.
REQ-031 Exit with empty FIFO SHALL assert halt exactly 1 + EXIT_DELAY edges after the accepting edge.
REQ-032 HALTED: halt = 1, remains until reset; req_ready = 0.
REQ-033 busy SHALL be 1 in DRAIN, DELAY, HALTED; 0 in RUN.
REQ-034 Pointers SHALL wrap modulo FIFO_DEPTH; occupancy 0..FIFO_DEPTH tracked exactly.

Reset
REQ-035 rst_n low SHALL immediately force state RUN, FIFO empty, delay counter 0, sys_count 0, halt 0, busy 0, disp_valid 0.
REQ-036 Reset asserted mid-DRAIN or mid-DELAY SHALL abort the exit; buffered display data is discarded.
REQ-037 First acceptance possible on the first rising edge after rst_n deasserts.

Verification
REQ-038 Defaults, disp_ready = 1; display syscalls 0xA, 0xB, 0xC back-to-back -> disp_data 0xA, 0xB, 0xC in order, sys_count = 3.
REQ-039 disp_ready = 0; 9 display requests -> 8 accepted, req_ready = 0 afterwards; one pop -> req_ready = 1 next cycle, 9th accepted.
REQ-040 Exit with empty FIFO accepted at edge k -> busy = 1 after edge k; halt = 1 after edge k+6; halt stays 1; req_ready = 0.
REQ-041 3 entries buffered, disp_ready = 0, exit accepted -> halt stays 0 while entries remain; release disp_ready -> 3 pops, then halt 1+5 edges after the empty point.
REQ-042 instr_id = 25 with code 1 -> no push, sys_count unchanged; code 7 with instr_id = 26 -> sys_count +1, no push.
REQ-043 Reset pulsed during DELAY -> halt 0, busy 0, FIFO empty, sys_count 0 immediately; new display accepted after release.

Source files
------------

// File: rtl/syscall_ctrl.sv
// System-instruction controller: decodes display/exit/nop syscalls, buffers
// display values in a FIFO and runs the drain / delay / halt exit sequence.
module syscall_ctrl #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned EXIT_DELAY = 5,
  parameter int unsigned SYSCALL_ID = 26
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] instr_id,
  input  logic [DATA_W-1:0] sys_code,
  input  logic [DATA_W-1:0] sys_arg,
  output logic              disp_valid,
  input  logic              disp_ready,
  output logic [DATA_W-1:0] disp_data,
  output logic              busy,
  output logic              halt,
  output logic [DATA_W-1:0] sys_count
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;
  localparam int unsigned DLY_W = $clog2(EXIT_DELAY + 1);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    DELAY  = 2'd2,
    HALTED = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]  occ_q, occ_d;
  logic [DLY_W-1:0]  dly_q, dly_d;
  logic [DATA_W-1:0] sys_count_q, sys_count_d;
  logic              halt_q, halt_d;
  logic              busy_q, busy_d;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];

  logic fifo_full, fifo_empty, accept, is_sys, push, pop, do_exit;

  assign fifo_full  = (occ_q == OCC_W'(FIFO_DEPTH));
  assign fifo_empty = (occ_q == '0);
  assign req_ready  = (state_q == RUN) && !fifo_full;
  assign disp_valid = !fifo_empty;
  assign disp_data  = mem[rd_ptr_q];
  assign busy       = busy_q;
  assign halt       = halt_q;
  assign sys_count  = sys_count_q;

  assign accept  = req_valid && req_ready;
  assign is_sys  = (instr_id == DATA_W'(SYSCALL_ID));
  assign push    = accept && is_sys && (sys_code == DATA_W'(1));
  assign do_exit = accept && is_sys && (sys_code == DATA_W'(2));
  assign pop     = disp_valid && disp_ready;

  // Next-state, FIFO bookkeeping and registered output values
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    occ_d       = occ_q;
    dly_d       = dly_q;
    sys_count_d = sys_count_q;

    case (state_q)
      RUN: begin
        if (do_exit) state_d = DRAIN;
      end
      DRAIN: begin
        if (fifo_empty) begin
          state_d = DELAY;
          dly_d   = '0;
        end
      end
      DELAY: begin
        if (dly_q == DLY_W'(EXIT_DELAY - 1)) state_d = HALTED;
        else                                  dly_d   = dly_q + DLY_W'(1);
      end
      HALTED:  state_d = HALTED;
      default: state_d = RUN;
    endcase

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase

    if (accept && is_sys) sys_count_d = sys_count_q + DATA_W'(1);

    halt_d = (state_d == HALTED);
    busy_d = (state_d != RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      dly_q       <= '0;
      sys_count_q <= '0;
      halt_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      dly_q       <= dly_d;
      sys_count_q <= sys_count_d;
      halt_q      <= halt_d;
      busy_q      <= busy_d;
    end
  end

  // Storage needs no reset: occupancy alone defines which entries are live
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= sys_arg;
  end

endmodule

// File: tb/tb_syscall_ctrl.sv
// Self-checking bench for syscall_ctrl: display values are scoreboarded in a
// queue at acceptance and compared in order as the FIFO head is consumed.
module tb_syscall_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] instr_id;
  logic [31:0] sys_code;
  logic [31:0] sys_arg;
  logic        disp_valid;
  logic        disp_ready;
  logic [31:0] disp_data;
  logic        busy;
  logic        halt;
  logic [31:0] sys_count;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [31:0] exp_q[$];

  syscall_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .instr_id   (instr_id),
    .sys_code   (sys_code),
    .sys_arg    (sys_arg),
    .disp_valid (disp_valid),
    .disp_ready (disp_ready),
    .disp_data  (disp_data),
    .busy       (busy),
    .halt       (halt),
    .sys_count  (sys_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present one request and hold it until accepted; returns 1ns after the accepting edge
  task automatic send(input logic [31:0] id, input logic [31:0] code, input logic [31:0] arg);
    int n;
    req_valid = 1'b1;
    instr_id  = id;
    sys_code  = code;
    sys_arg   = arg;
    n = 0;
    forever begin
      @(negedge clk);
      if (req_ready) break;
      n++;
      if (n > 100) begin
        check("accept_timeout", 32'(req_ready), 32'd1);
        req_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    if (id == 32'd26 && code == 32'd1) exp_q.push_back(arg);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_drained();
    for (int i = 0; i < 100; i++) begin
      if (!disp_valid) return;
      tick(1);
    end
    check("drain_timeout", 32'(disp_valid), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exp_q.delete();
    tick(2);
    rst_n = 1'b1;
  endtask

  // Consumer side: every head taken must match the oldest expected value
  always @(negedge clk) begin
    if (rst_n && disp_valid && disp_ready) begin
      if (exp_q.size() == 0) check("disp_unexpected_pop", 32'(exp_q.size()), 32'd1);
      else check("disp_data", disp_data, exp_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    instr_id   = '0;
    sys_code   = '0;
    sys_arg    = '0;
    disp_ready = 1'b1;
    tick(2);
    check("rst_disp_valid", 32'(disp_valid), 32'd0);
    check("rst_halt",       32'(halt),       32'd0);
    check("rst_busy",       32'(busy),       32'd0);
    check("rst_sys_count",  sys_count,       32'd0);
    rst_n = 1'b1;
    #1;
    check("rst_req_ready",  32'(req_ready),  32'd1);

    // Back-to-back display syscalls with an always-ready consumer
    send(32'd26, 32'd1, 32'h0A);
    send(32'd26, 32'd1, 32'h0B);
    send(32'd26, 32'd1, 32'h0C);
    wait_drained();
    check("b2b_sys_count", sys_count, 32'd3);

    // Non-syscall instruction and nop code
    send(32'd25, 32'd1, 32'hDEAD);
    tick(2);
    check("nonsys_disp_valid", 32'(disp_valid), 32'd0);
    check("nonsys_sys_count",  sys_count,       32'd3);
    send(32'd26, 32'd7, 32'hBEEF);
    check("nop_sys_count",  sys_count,       32'd4);
    tick(1);
    check("nop_disp_valid", 32'(disp_valid), 32'd0);
    check("nop_busy",       32'(busy),       32'd0);

    // Fill the FIFO with the consumer stalled, then free exactly one slot
    disp_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(32'd26, 32'd1, 32'h100 + 32'(i));
    check("full_req_ready",  32'(req_ready),  32'd0);
    check("full_disp_valid", 32'(disp_valid), 32'd1);
    req_valid = 1'b1;
    instr_id  = 32'd26;
    sys_code  = 32'd1;
    sys_arg   = 32'h109;
    tick(2);
    check("full_blocked_count", sys_count,      32'd12);
    check("full_blocked_ready", 32'(req_ready), 32'd0);
    disp_ready = 1'b1;
    tick(1);
    disp_ready = 1'b0;
    check("pop_frees_ready", 32'(req_ready), 32'd1);
    exp_q.push_back(32'h109);
    tick(1);
    req_valid = 1'b0;
    check("ninth_sys_count", sys_count,      32'd13);
    check("refull_ready",    32'(req_ready), 32'd0);
    disp_ready = 1'b1;
    wait_drained();

    // Exit with entries still buffered: halt only after the drain plus delay
    disp_ready = 1'b0;
    send(32'd26, 32'd1, 32'h31);
    send(32'd26, 32'd1, 32'h32);
    send(32'd26, 32'd1, 32'h33);
    send(32'd26, 32'd2, 32'h0);
    check("drain_busy",      32'(busy),      32'd1);
    check("drain_req_ready", 32'(req_ready), 32'd0);
    tick(4);
    check("drain_hold_halt",  32'(halt),       32'd0);
    check("drain_hold_valid", 32'(disp_valid), 32'd1);
    disp_ready = 1'b1;
    tick(8);
    check("drain_halt_early", 32'(halt), 32'd0);
    tick(1);
    check("drain_halt",      32'(halt),  32'd1);
    check("drain_sys_count", sys_count,  32'd17);

    // Exit with an empty FIFO: halt exactly 1 + EXIT_DELAY edges later
    do_reset();
    send(32'd26, 32'd2, 32'h0);
    check("exit_busy",       32'(busy), 32'd1);
    check("exit_halt_k",     32'(halt), 32'd0);
    tick(5);
    check("exit_halt_k5",    32'(halt), 32'd0);
    tick(1);
    check("exit_halt_k6",    32'(halt), 32'd1);
    tick(3);
    check("exit_halt_stays", 32'(halt),      32'd1);
    check("exit_req_ready",  32'(req_ready), 32'd0);
    check("exit_busy_halted", 32'(busy),     32'd1);

    // Reset in the middle of the delay phase aborts the exit
    do_reset();
    disp_ready = 1'b0;
    send(32'd26, 32'd1, 32'h77);
    send(32'd26, 32'd2, 32'h0);
    disp_ready = 1'b1;
    tick(4);
    check("pre_rst_busy", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("midrst_halt",       32'(halt),       32'd0);
    check("midrst_busy",       32'(busy),       32'd0);
    check("midrst_disp_valid", 32'(disp_valid), 32'd0);
    check("midrst_sys_count",  sys_count,       32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(32'd26, 32'd1, 32'h55);
    check("post_rst_count", sys_count, 32'd1);
    wait_drained();
    tick(2);
    check("post_rst_halt",  32'(halt),         32'd0);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
